bus_master_port: RTL and testbench

Master-side bus interface that sits directly downstream of the command processor, one instance per master (m1, m2). It latches a parallel request (slave, address, burst, data, instruction), requests and holds the bus from the arbiter, and serialises a header plus write data MSB-first. For reads it deserialises the slave's response words and returns them with new_rx/rx_done; for writes it signals tx_done.

---
 rtl/bus_master_port.sv | 266 ++++++++++++++++++++++++++
 tb/tb_bus_master_port.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - master-side serial bus port; optional abort logic under BMP_TIMEOUT_EN
module bus_master_port #(
  parameter int SLAVE_LEN   = 2,
  parameter int ADDR_LEN    = 12,
  parameter int DATA_LEN    = 8,
  parameter int BURST_LEN   = 12,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ADDR_LEN-1:0]  address,
  input  logic [DATA_LEN-1:0]  data,
  input  logic [BURST_LEN-1:0] burst_num,
  input  logic [SLAVE_LEN-1:0] slave_select,
  input  logic [1:0]           instruction,
  output logic                 tx_done,
  output logic                 new_rx,
  output logic                 rx_done,
  output logic [DATA_LEN-1:0]  new_data,
  output logic                 bus_req,
  input  logic                 bus_grant,
  output logic                 m_valid,
  output logic                 m_dout,
  input  logic                 s_ready,
  input  logic                 s_valid,
  input  logic                 s_din,
  output logic                 err
);

  localparam int HDR_LEN = SLAVE_LEN + 1 + ADDR_LEN + BURST_LEN;
  localparam int CNT_MAX = (HDR_LEN > DATA_LEN) ? HDR_LEN : DATA_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BEAT_W  = BURST_LEN + 1;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DATA_LEN - 1);

  typedef enum logic [2:0] {IDLE, REQ, HEADER, WAIT_ACK, WDATA, RDATA, DONE} state_t;

  state_t               state_q, state_d;
  logic                 rw_q, rw_d;
  logic [BEAT_W-1:0]    beats_q, beats_d;
  logic [HDR_LEN-1:0]   hdr_q, hdr_d;
  logic [DATA_LEN-1:0]  sr_q, sr_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [DATA_LEN-1:0]  new_data_q, new_data_d;
  logic                 bus_req_q, bus_req_d;
  logic                 m_valid_q, m_valid_d;
  logic                 m_dout_q, m_dout_d;
  logic                 tx_done_q, tx_done_d;
  logic                 new_rx_q, new_rx_d;
  logic                 rx_done_q, rx_done_d;
  logic [BURST_LEN-1:0] hdr_beats;
  logic                 last_beat;

`ifdef BMP_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            err_q, err_d;
  logic            stall, grant_lost;
`else
  // TIMEOUT_CYC only matters when the abort logic is built
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
`endif

  // beats field on the wire is (beats - 1), with 0 requested beats treated as 1
  assign hdr_beats = (burst_num == '0) ? '0 : burst_num - BURST_LEN'(1);
  assign last_beat = (beat_cnt_q == beats_q - BEAT_W'(1));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next-state and next-output logic; outputs are registered below
  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    beats_d    = beats_q;
    hdr_d      = hdr_q;
    sr_d       = sr_q;
    bit_cnt_d  = bit_cnt_q;
    beat_cnt_d = beat_cnt_q;
    new_data_d = new_data_q;
    bus_req_d  = bus_req_q;
    m_valid_d  = 1'b0;
    m_dout_d   = 1'b0;
    tx_done_d  = 1'b0;
    new_rx_d   = 1'b0;
    rx_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (instruction[1]) begin
          rw_d       = instruction[0];
          beats_d    = (burst_num == '0) ? BEAT_W'(1) : {1'b0, burst_num};
          hdr_d      = {slave_select, instruction[0], address, hdr_beats};
          bit_cnt_d  = '0;
          beat_cnt_d = '0;
          bus_req_d  = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (bus_grant) begin
          m_valid_d = 1'b1;
          m_dout_d  = hdr_q[HDR_LEN-1];
          hdr_d     = hdr_q << 1;
          bit_cnt_d = '0;
          state_d   = HEADER;
        end
      end
      HEADER: begin
        if (bit_cnt_q == HDR_LAST) begin
          state_d = WAIT_ACK;
        end else begin
          m_valid_d = 1'b1;
          m_dout_d  = hdr_q[HDR_LEN-1];
          hdr_d     = hdr_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      WAIT_ACK: begin
        if (s_ready) begin
          bit_cnt_d  = '0;
          beat_cnt_d = '0;
          if (rw_q) begin
            state_d = RDATA;
          end else begin
            m_valid_d = 1'b1;
            m_dout_d  = data[DATA_LEN-1];
            sr_d      = {data[DATA_LEN-2:0], 1'b0};
            state_d   = WDATA;
          end
        end
      end
      WDATA: begin
        if (bit_cnt_q == BIT_LAST) begin
          if (last_beat) begin
            tx_done_d = 1'b1;
            bus_req_d = 1'b0;
            state_d   = DONE;
          end else begin
            // next beat starts immediately with a fresh sample of data
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            bit_cnt_d  = '0;
            m_valid_d  = 1'b1;
            m_dout_d   = data[DATA_LEN-1];
            sr_d       = {data[DATA_LEN-2:0], 1'b0};
          end
        end else begin
          m_valid_d = 1'b1;
          m_dout_d  = sr_q[DATA_LEN-1];
          sr_d      = sr_q << 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      RDATA: begin
        if (s_valid) begin
          sr_d = {sr_q[DATA_LEN-2:0], s_din};
          if (bit_cnt_q == BIT_LAST) begin
            new_data_d = {sr_q[DATA_LEN-2:0], s_din};
            new_rx_d   = 1'b1;
            bit_cnt_d  = '0;
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            if (last_beat) begin
              rx_done_d = 1'b1;
              bus_req_d = 1'b0;
              state_d   = DONE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        bus_req_d = 1'b0;
        if (!instruction[1]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef BMP_TIMEOUT_EN
    err_d      = 1'b0;
    to_cnt_d   = '0;
    stall      = ((state_q == REQ) && !bus_grant) ||
                 ((state_q == WAIT_ACK) && !s_ready) ||
                 ((state_q == RDATA) && !s_valid);
    grant_lost = !bus_grant && ((state_q == HEADER) || (state_q == WAIT_ACK) ||
                                (state_q == WDATA) || (state_q == RDATA));
    if (stall) to_cnt_d = to_cnt_q + TO_W'(1);
    // abort overrides whatever the state machine decided this cycle
    if (grant_lost || (stall && (to_cnt_q == TO_LAST))) begin
      state_d    = DONE;
      bus_req_d  = 1'b0;
      m_valid_d  = 1'b0;
      m_dout_d   = 1'b0;
      tx_done_d  = 1'b0;
      new_rx_d   = 1'b0;
      rx_done_d  = 1'b0;
      new_data_d = new_data_q;
      err_d      = 1'b1;
      to_cnt_d   = '0;
    end
`endif
  end

  // datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      rw_q       <= 1'b0;
      beats_q    <= '0;
      hdr_q      <= '0;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      beat_cnt_q <= '0;
      new_data_q <= '0;
      bus_req_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_dout_q   <= 1'b0;
      tx_done_q  <= 1'b0;
      new_rx_q   <= 1'b0;
      rx_done_q  <= 1'b0;
    end else begin
      rw_q       <= rw_d;
      beats_q    <= beats_d;
      hdr_q      <= hdr_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      new_data_q <= new_data_d;
      bus_req_q  <= bus_req_d;
      m_valid_q  <= m_valid_d;
      m_dout_q   <= m_dout_d;
      tx_done_q  <= tx_done_d;
      new_rx_q   <= new_rx_d;
      rx_done_q  <= rx_done_d;
    end
  end

`ifdef BMP_TIMEOUT_EN
  // stall counter and abort pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign bus_req  = bus_req_q;
  assign m_valid  = m_valid_q;
  assign m_dout   = m_dout_q;
  assign tx_done  = tx_done_q;
  assign new_rx   = new_rx_q;
  assign rx_done  = rx_done_q;
  assign new_data = new_data_q;

endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - self-checking bench for bus_master_port
module tb_bus_master_port;
  localparam int HDR_LEN = 27;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address = '0;
  logic [7:0]  data = '0;
  logic [11:0] burst_num = '0;
  logic [1:0]  slave_select = '0;
  logic [1:0]  instruction = '0;
  logic        tx_done, new_rx, rx_done, bus_req, m_valid, m_dout, err;
  logic [7:0]  new_data;
  logic        bus_grant = 1'b0;
  logic        s_ready = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_din = 1'b0;

  always #5 clk = ~clk;

  bus_master_port #(
    .SLAVE_LEN(2), .ADDR_LEN(12), .DATA_LEN(8), .BURST_LEN(12), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .data(data), .burst_num(burst_num),
    .slave_select(slave_select), .instruction(instruction), .tx_done(tx_done),
    .new_rx(new_rx), .rx_done(rx_done), .new_data(new_data), .bus_req(bus_req),
    .bus_grant(bus_grant), .m_valid(m_valid), .m_dout(m_dout), .s_ready(s_ready),
    .s_valid(s_valid), .s_din(s_din), .err(err)
  );

  typedef struct {
    logic [1:0]  slv;
    logic [11:0] addr;
    logic [11:0] burst;
    logic        rd;
    logic [7:0]  w0;
    logic [7:0]  w1;
    int          grant_dly;
    int          ack_dly;
    bit          gap;
    logic [26:0] exp_hdr;
    int          exp_beats;
  } vec_t;

  typedef struct packed {
    logic [7:0] word;
    logic       last;
  } rx_exp_t;

  vec_t    vecs[5];
  logic    exp_bits[$];
  rx_exp_t exp_rx[$];
  rx_exp_t e_rx;
  int      n_checks = 0;
  int      n_fail = 0;
  int      exp_tx = 0;
  int      tx_cnt = 0;
  int      rx_cnt = 0;
  bit      chk_bits = 1'b1;
  logic    prev_m_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard: pops expectations as the DUT produces serial bits and pulses
  always @(negedge clk) begin
    if (m_valid && chk_bits) begin
      check("expected bit pending at m_valid", exp_bits.size() > 0, 1);
      if (exp_bits.size() > 0) check("m_dout bit", m_dout, exp_bits.pop_front());
    end
    if (new_rx) begin
      check("expected word pending at new_rx", exp_rx.size() > 0, 1);
      if (exp_rx.size() > 0) begin
        e_rx = exp_rx.pop_front();
        check("new_data", new_data, e_rx.word);
        check("rx_done with final new_rx", rx_done, e_rx.last);
      end
    end
    if (rx_done) begin
      rx_cnt++;
      check("rx_done coincides with new_rx", new_rx, 1);
    end
    if (tx_done) begin
      tx_cnt++;
      check("tx_done expected", exp_tx > 0, 1);
      check("tx_done one cycle after last bit", {prev_m_valid, m_valid}, 2'b10);
      if (exp_tx > 0) exp_tx--;
    end
    prev_m_valid = m_valid;
  end

  task automatic wait_for(input int sel, input logic lvl, input int limit,
                          input string name, output int n);
    logic s;
    n = 0;
    s = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      case (sel)
        0:       s = bus_req;
        1:       s = m_valid;
        2:       s = tx_done;
        default: s = err;
      endcase
      if (s == lvl || n >= limit) break;
    end
    check({name, " within bound"}, s == lvl, 1);
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int tx0;
    int rx0;
    logic [7:0] w;
    for (int i = HDR_LEN - 1; i >= 0; i--) exp_bits.push_back(v.exp_hdr[i]);
    if (!v.rd) begin
      for (int b = 0; b < v.exp_beats; b++) begin
        w = (b == 0) ? v.w0 : v.w1;
        for (int i = 7; i >= 0; i--) exp_bits.push_back(w[i]);
      end
      exp_tx++;
    end
    tx0 = tx_cnt;
    rx0 = rx_cnt;
    slave_select = v.slv;
    address      = v.addr;
    burst_num    = v.burst;
    data         = v.w0;
    instruction  = {1'b1, v.rd};
    wait_for(0, 1'b1, 10, "bus_req rise", n);
    for (int k = 0; k < v.grant_dly; k++) begin
      check("bus_req held while waiting grant", bus_req, 1);
      check("m_valid low before grant", m_valid, 0);
      @(negedge clk);
    end
    bus_grant = 1'b1;
    wait_for(1, 1'b1, 5, "header start", n);
    check("first header bit one cycle after grant", n, 1);
    wait_for(1, 1'b0, HDR_LEN + 2, "header end", n);
    check("header length", n, HDR_LEN);
    repeat (v.ack_dly) @(negedge clk);
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    if (!v.rd) begin
      data = v.w1;
      wait_for(2, 1'b1, 8 * v.exp_beats + 4, "tx_done", n);
      check("tx_done latency", n, 8 * v.exp_beats);
      check("bus_req low in DONE", bus_req, 0);
    end else begin
      for (int b = 0; b < v.exp_beats; b++) begin
        w = (b == 0) ? v.w0 : v.w1;
        for (int i = 7; i >= 0; i--) begin
          if (v.gap && b == 0 && i == 3) begin
            s_valid = 1'b0;
            s_din   = 1'b0;
            @(negedge clk);
          end
          s_valid = 1'b1;
          s_din   = w[i];
          if (i == 0) exp_rx.push_back({w, b == v.exp_beats - 1});
          @(negedge clk);
        end
      end
      s_valid = 1'b0;
      s_din   = 1'b0;
      check("bus_req low in DONE", bus_req, 0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no retrigger while instruction held", bus_req | m_valid, 0);
    end
    check("tx_done count", tx_cnt - tx0, v.rd ? 0 : 1);
    check("rx_done count", rx_cnt - rx0, v.rd ? 1 : 0);
    check("serial bits drained", exp_bits.size(), 0);
    check("read words drained", exp_rx.size(), 0);
    instruction = 2'b00;
    bus_grant   = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " bus_req"}, bus_req, 0);
    check({tag, " m_valid"}, m_valid, 0);
    check({tag, " m_dout"}, m_dout, 0);
    check({tag, " tx_done"}, tx_done, 0);
    check({tag, " new_rx"}, new_rx, 0);
    check({tag, " rx_done"}, rx_done, 0);
    check({tag, " err"}, err, 0);
    check({tag, " new_data"}, new_data, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int tx0;
    //            slv    addr     burst  rd    w0     w1     gdly ack gap exp_hdr                                 beats
    vecs[0] = '{2'd2, 12'h005, 12'd0, 1'b0, 8'hA5, 8'h00, 0,  2,  1'b0, 27'b10_0_0000_0000_0101_0000_0000_0000, 1};
    vecs[1] = '{2'd1, 12'h0F0, 12'd2, 1'b1, 8'h3C, 8'hC3, 0,  1,  1'b1, 27'b01_1_0000_1111_0000_0000_0000_0001, 2};
    vecs[2] = '{2'd3, 12'hABC, 12'd2, 1'b0, 8'h5A, 8'h0F, 10, 0,  1'b0, 27'b11_0_1010_1011_1100_0000_0000_0001, 2};
    vecs[3] = '{2'd0, 12'hFFF, 12'd1, 1'b1, 8'h81, 8'h00, 3,  4,  1'b0, 27'b00_1_1111_1111_1111_0000_0000_0000, 1};
    vecs[4] = '{2'd1, 12'h800, 12'd3, 1'b0, 8'h12, 8'h34, 1,  3,  1'b0, 27'b01_0_1000_0000_0000_0000_0000_0010, 3};

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) run_txn(vecs[i]);

    // reset in the middle of a header
    for (int i = HDR_LEN - 1; i >= 0; i--) exp_bits.push_back(n_fail >= 0 ? 1'b0 : 1'b1);
    exp_bits.delete();
    begin
      logic [26:0] hdr;
      hdr = 27'b10_0_0001_0010_0011_0000_0000_0000;
      for (int i = HDR_LEN - 1; i >= 0; i--) exp_bits.push_back(hdr[i]);
    end
    tx0 = tx_cnt;
    slave_select = 2'd2;
    address      = 12'h123;
    burst_num    = 12'd0;
    data         = 8'hFF;
    instruction  = 2'b10;
    wait_for(0, 1'b1, 10, "reset test bus_req", n);
    bus_grant = 1'b1;
    wait_for(1, 1'b1, 5, "reset test header start", n);
    repeat (5) @(negedge clk);
    check("header bit 5 on wire", m_valid, 1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid-frame reset");
    exp_bits.delete();
    instruction = 2'b00;
    bus_grant   = 1'b0;
    reset       = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("idle after reset", bus_req | m_valid | tx_done, 0);
    end
    check("no tx_done after aborted frame", tx_cnt - tx0, 0);
    run_txn(vecs[0]);

`ifdef BMP_TIMEOUT_EN
    // s_ready never arrives
    chk_bits     = 1'b0;
    tx0          = tx_cnt;
    slave_select = 2'd1;
    address      = 12'h010;
    burst_num    = 12'd0;
    instruction  = 2'b10;
    wait_for(0, 1'b1, 10, "timeout bus_req", n);
    bus_grant = 1'b1;
    wait_for(1, 1'b1, 5, "timeout header start", n);
    wait_for(1, 1'b0, HDR_LEN + 2, "timeout header end", n);
    wait_for(3, 1'b1, 40, "err on ack timeout", n);
    check("ack timeout cycles", n, 16);
    check("bus_req dropped on timeout", bus_req, 0);
    check("m_valid dropped on timeout", m_valid, 0);
    @(negedge clk);
    check("err is a single pulse", err, 0);
    instruction = 2'b00;
    bus_grant   = 1'b0;
    repeat (2) @(negedge clk);
    // grant withdrawn mid write data
    data        = 8'hF0;
    instruction = 2'b10;
    wait_for(0, 1'b1, 10, "grant-loss bus_req", n);
    bus_grant = 1'b1;
    wait_for(1, 1'b1, 5, "grant-loss header start", n);
    wait_for(1, 1'b0, HDR_LEN + 2, "grant-loss header end", n);
    s_ready = 1'b1;
    @(negedge clk);
    s_ready = 1'b0;
    repeat (3) @(negedge clk);
    bus_grant = 1'b0;
    wait_for(3, 1'b1, 4, "err on grant loss", n);
    check("grant loss abort latency", n, 1);
    check("bus_req dropped on grant loss", bus_req, 0);
    check("m_valid dropped on grant loss", m_valid, 0);
    instruction = 2'b00;
    repeat (4) @(negedge clk);
    check("no tx_done on aborts", tx_cnt - tx0, 0);
    chk_bits = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
